// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//   Round controller for the rhythm game. It walks one round through
//   IDLE -> COUNTDOWN -> PLAYING (<-> PAUSED) -> FINISHED. It owns the play
//   timer, gates pattern writes, pulses the score clear and keeps the best
//   final score since reset.
//
// Ports
//   i_clock              system clock, all logic on the rising edge
//   i_reset              synchronous active-high reset, overrides everything
//   i_tick               one-cycle time-base strobe
//   i_start              one-cycle start pulse (debounced upstream)
//   i_pause              one-cycle pause toggle pulse
//   i_abort              one-cycle abort pulse, returns to IDLE
//   i_score    [10:0]    live score from the score block
//   o_state    [2:0]     IDLE=0 COUNTDOWN=1 PLAYING=2 PAUSED=3 FINISHED=4
//   o_game_timer [9:0]   elapsed play ticks
//   o_countdown_digit [3:0] seconds left in countdown, 0 elsewhere
//   o_game_run           high only while PLAYING
//   o_pattern_write_en   high in IDLE and FINISHED
//   o_score_clear        one-cycle pulse on entry to COUNTDOWN
//   o_high_score [10:0]  best final score since reset
//   o_new_record         high in FINISHED when this round beat the record
//
// Input priority within a cycle: reset > abort > start > pause > tick.
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int TICKS_PER_SEC  = 100,
    parameter int COUNTDOWN_SECS = 3,
    parameter int GAME_LENGTH    = 1000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_tick,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_abort,
    input  logic [10:0] i_score,
    output logic [2:0]  o_state,
    output logic [9:0]  o_game_timer,
    output logic [3:0]  o_countdown_digit,
    output logic        o_game_run,
    output logic        o_pattern_write_en,
    output logic        o_score_clear,
    output logic [10:0] o_high_score,
    output logic        o_new_record
);

    // Sub-counter needs at least one bit even when TICKS_PER_SEC is 1.
    localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [9:0]       TIMER_LAST = 10'(GAME_LENGTH - 1);
    localparam logic [9:0]       TIMER_END  = 10'(GAME_LENGTH);
    localparam logic [3:0]       DIGIT_INIT = 4'(COUNTDOWN_SECS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAYING   = 3'd2,
        S_PAUSED    = 3'd3,
        S_FINISHED  = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [9:0]         r_timer;
    logic [SUB_W-1:0]   r_sub;
    logic [3:0]         r_digit;
    logic               r_score_clear;
    logic [10:0]        r_high_score;
    logic               r_new_record;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    state_t             w_state_nx;
    logic [9:0]         w_timer_nx;
    logic [SUB_W-1:0]   w_sub_nx;
    logic [3:0]         w_digit_nx;
    logic               w_score_clear_nx;
    logic [10:0]        w_high_score_nx;
    logic               w_new_record_nx;

    // Shared transition actions, applied after the per-state decode.
    logic               w_go_idle;
    logic               w_go_countdown;
    logic               w_final_tick;

    always_comb begin
        w_go_idle      = 1'b0;
        w_go_countdown = 1'b0;
        w_final_tick   = 1'b0;

        w_state_nx       = r_state;
        w_timer_nx       = r_timer;
        w_sub_nx         = r_sub;
        w_digit_nx       = r_digit;
        w_score_clear_nx = 1'b0;
        w_high_score_nx  = r_high_score;
        w_new_record_nx  = r_new_record;

        case (r_state)
            S_IDLE: begin
                // abort outranks start, and abort in IDLE is a no-op, so a
                // simultaneous abort+start leaves the sequencer idle.
                if (!i_abort && i_start)
                    w_go_countdown = 1'b1;
            end

            S_COUNTDOWN: begin
                if (i_abort) begin
                    w_go_idle = 1'b1;
                end else if (i_tick) begin
                    if (r_sub == SUB_LAST) begin
                        w_sub_nx = '0;
                        if (r_digit == 4'd1) begin
                            w_digit_nx = 4'd0;
                            w_state_nx = S_PLAYING;
                        end else begin
                            w_digit_nx = r_digit - 4'd1;
                        end
                    end else begin
                        w_sub_nx = r_sub + SUB_W'(1);
                    end
                end
            end

            S_PLAYING: begin
                if (i_abort) begin
                    w_go_idle = 1'b1;
                end else if (i_pause) begin
                    // A tick coinciding with pause is dropped on purpose so
                    // the timer freezes at the value seen when pause hit.
                    w_state_nx = S_PAUSED;
                end else if (i_tick) begin
                    if (r_timer == TIMER_LAST) begin
                        w_timer_nx   = TIMER_END;
                        w_state_nx   = S_FINISHED;
                        w_final_tick = 1'b1;
                    end else begin
                        w_timer_nx = r_timer + 10'd1;
                    end
                end
            end

            S_PAUSED: begin
                if (i_abort)
                    w_go_idle = 1'b1;
                else if (i_pause)
                    w_state_nx = S_PLAYING;
            end

            S_FINISHED: begin
                if (i_abort)
                    w_go_idle = 1'b1;
                else if (i_start)
                    w_go_countdown = 1'b1;
            end

            default: begin
                w_go_idle = 1'b1;
            end
        endcase

        // Record check uses the live score of the final tick cycle; a tie
        // does not count as a new record.
        if (w_final_tick) begin
            if (i_score > r_high_score) begin
                w_high_score_nx = i_score;
                w_new_record_nx = 1'b1;
            end else begin
                w_new_record_nx = 1'b0;
            end
        end

        if (w_go_countdown) begin
            w_state_nx       = S_COUNTDOWN;
            w_timer_nx       = '0;
            w_sub_nx         = '0;
            w_digit_nx       = DIGIT_INIT;
            w_new_record_nx  = 1'b0;
            w_score_clear_nx = 1'b1;
        end

        // high_score deliberately survives abort; only reset clears it.
        if (w_go_idle) begin
            w_state_nx      = S_IDLE;
            w_timer_nx      = '0;
            w_sub_nx        = '0;
            w_digit_nx      = '0;
            w_new_record_nx = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_sub         <= '0;
            r_digit       <= '0;
            r_score_clear <= 1'b0;
            r_high_score  <= '0;
            r_new_record  <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_timer       <= w_timer_nx;
            r_sub         <= w_sub_nx;
            r_digit       <= w_digit_nx;
            r_score_clear <= w_score_clear_nx;
            r_high_score  <= w_high_score_nx;
            r_new_record  <= w_new_record_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: registers or decodes of the registered state only
    // -------------------------------------------------------------------------
    assign o_state            = r_state;
    assign o_game_timer       = r_timer;
    assign o_countdown_digit  = r_digit;
    assign o_game_run         = (r_state == S_PLAYING);
    assign o_pattern_write_en = (r_state == S_IDLE) || (r_state == S_FINISHED);
    assign o_score_clear      = r_score_clear;
    assign o_high_score       = r_high_score;
    assign o_new_record       = r_new_record;

endmodule
